// File: rtl/path_pkg.sv
// Shared types for the path sequencer: node ID type, invalid-node marker, sequencer states.
package path_pkg;

  localparam int NODE_W = 5;

  typedef logic [NODE_W-1:0] node_t;

  localparam node_t INVALID_NODE = {NODE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/path_mem.sv
// Path register file: one synchronous write port, three combinational guarded read ports.
// Reads at or beyond the stored length return the all-ones invalid node; no backpressure.
module path_mem #(
  parameter int  NODE_W = path_pkg::NODE_W,
  parameter int  DEPTH  = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_3125k,
  input  logic              i_wr_en,
  input  logic [PTR_W-1:0]  i_wr_addr,
  input  logic [NODE_W-1:0] i_wr_node,
  input  logic [PTR_W:0]    i_len,
  input  logic [PTR_W:0]    i_rd0_addr,
  input  logic [PTR_W:0]    i_rd1_addr,
  input  logic [PTR_W:0]    i_rd2_addr,
  output logic [NODE_W-1:0] o_rd0_node,
  output logic [NODE_W-1:0] o_rd1_node,
  output logic [NODE_W-1:0] o_rd2_node
);
  import path_pkg::*;

  localparam logic [NODE_W-1:0] NODE_INV = {NODE_W{1'b1}};

  logic [NODE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_3125k) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_node;
  end

  // Addresses are one bit wider than the index so cursor-1 at 0 wraps far past i_len.
  assign o_rd0_node = (i_rd0_addr < i_len) ? r_mem[i_rd0_addr[PTR_W-1:0]] : NODE_INV;
  assign o_rd1_node = (i_rd1_addr < i_len) ? r_mem[i_rd1_addr[PTR_W-1:0]] : NODE_INV;
  assign o_rd2_node = (i_rd2_addr < i_len) ? r_mem[i_rd2_addr[PTR_W-1:0]] : NODE_INV;

endmodule

// File: rtl/path_sequencer.sv
// Loadable path cursor presenting registered prev/curr/next node IDs; node outputs lag the cursor
// by one cycle, pulses act in the cycle sampled (no backpressure). PATH_SEQ_REVERSE_EN adds rev.
module path_sequencer #(
  parameter int  NODE_W = path_pkg::NODE_W,
  parameter int  DEPTH  = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_3125k,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [NODE_W-1:0] wr_node,
  input  logic              start,
  input  logic              advance,
`ifdef PATH_SEQ_REVERSE_EN
  input  logic              rev,
`endif
  output logic [NODE_W-1:0] prev_node,
  output logic [NODE_W-1:0] curr_node,
  output logic [NODE_W-1:0] next_node,
  output logic [PTR_W-1:0]  cursor,
  output logic [PTR_W:0]    path_len,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_empty
);
  import path_pkg::*;

  localparam logic [NODE_W-1:0] NODE_INV = {NODE_W{1'b1}};

  seq_state_t        r_state;
  logic [PTR_W-1:0]  r_cursor;
  logic [PTR_W:0]    r_len;
  logic              r_rev;
  logic              r_busy, r_done, r_err_ovf, r_err_empty;
  logic [NODE_W-1:0] r_prev, r_curr, r_next;

  logic              w_rev_in;
  logic              w_full;
  logic              w_at_end;
  logic              w_wr_en;
  logic [PTR_W:0]    w_len_m1;
  logic [PTR_W-1:0]  w_start_cur;
  logic [PTR_W:0]    w_addr_lo, w_addr_mid, w_addr_hi;
  logic [NODE_W-1:0] w_rd_lo, w_rd_mid, w_rd_hi;

`ifdef PATH_SEQ_REVERSE_EN
  assign w_rev_in = rev;
`else
  assign w_rev_in = 1'b0;
`endif

  assign w_full      = (r_len == (PTR_W+1)'(DEPTH));
  assign w_len_m1    = r_len - (PTR_W+1)'(1);
  assign w_start_cur = w_rev_in ? w_len_m1[PTR_W-1:0] : '0;
  assign w_at_end    = r_rev ? (r_cursor == '0) : ({1'b0, r_cursor} == w_len_m1);
  // Writes lose to clr and start in the same cycle and only land while idle.
  assign w_wr_en     = (r_state == IDLE) && !clr && !start && wr_en && !w_full;

  assign w_addr_lo  = {1'b0, r_cursor} - (PTR_W+1)'(1);
  assign w_addr_mid = {1'b0, r_cursor};
  assign w_addr_hi  = {1'b0, r_cursor} + (PTR_W+1)'(1);

  path_mem #(
    .NODE_W (NODE_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_3125k  (clk_3125k),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (r_len[PTR_W-1:0]),
    .i_wr_node  (wr_node),
    .i_len      (r_len),
    .i_rd0_addr (w_addr_lo),
    .i_rd1_addr (w_addr_mid),
    .i_rd2_addr (w_addr_hi),
    .o_rd0_node (w_rd_lo),
    .o_rd1_node (w_rd_mid),
    .o_rd2_node (w_rd_hi)
  );

  always_ff @(posedge clk_3125k) begin
    if (!rst_n || clr) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cursor    <= '0;
      r_rev       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (r_len != '0) begin
              r_state  <= RUN;
              r_cursor <= w_start_cur;
              r_rev    <= w_rev_in;
              r_busy   <= 1'b1;
            end else begin
              r_err_empty <= 1'b1;
            end
          end else if (wr_en) begin
            if (w_full) r_err_ovf <= 1'b1;
            else        r_len     <= r_len + (PTR_W+1)'(1);
          end
        end
        RUN: begin
          if (advance) begin
            if (w_at_end) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cursor <= r_rev ? r_cursor - PTR_W'(1) : r_cursor + PTR_W'(1);
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state  <= RUN;
            r_cursor <= w_start_cur;
            r_rev    <= w_rev_in;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reverse traversal swaps which neighbour is presented as next versus prev.
  always_ff @(posedge clk_3125k) begin
    if (!rst_n || clr || r_state == IDLE) begin
      r_prev <= NODE_INV;
      r_curr <= NODE_INV;
      r_next <= NODE_INV;
    end else begin
      r_prev <= r_rev ? w_rd_hi : w_rd_lo;
      r_curr <= w_rd_mid;
      r_next <= r_rev ? w_rd_lo : w_rd_hi;
    end
  end

  assign prev_node    = r_prev;
  assign curr_node    = r_curr;
  assign next_node    = r_next;
  assign cursor       = r_cursor;
  assign path_len     = r_len;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_overflow = r_err_ovf;
  assign err_empty    = r_err_empty;

endmodule

// File: tb/tb_path_sequencer.sv
// Randomized bench for path_sequencer against a queue/index reference model.
`timescale 1ns/1ps
module tb_path_sequencer;
  import path_pkg::*;

  localparam int DP = 32;

  logic       clk_3125k = 1'b0;
  logic       rst_n, clr, wr_en, start, advance;
  logic [4:0] wr_node;
`ifdef PATH_SEQ_REVERSE_EN
  logic       rev;
`endif
  logic [4:0] prev_node, curr_node, next_node, cursor;
  logic [5:0] path_len;
  logic       busy, done, err_overflow, err_empty;

  always #160 clk_3125k = ~clk_3125k;

  path_sequencer #(.NODE_W(5), .DEPTH(DP)) dut (
    .clk_3125k    (clk_3125k),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_node      (wr_node),
    .start        (start),
    .advance      (advance),
`ifdef PATH_SEQ_REVERSE_EN
    .rev          (rev),
`endif
    .prev_node    (prev_node),
    .curr_node    (curr_node),
    .next_node    (next_node),
    .cursor       (cursor),
    .path_len     (path_len),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .err_empty    (err_empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the stored path as a plain array plus an index and a mode.
  int m_mem[DP];
  int m_len, m_cur, m_state; // m_state: 0 idle, 1 run, 2 done
  bit m_rev, m_ovf, m_emp;

  task automatic m_reset();
    m_len = 0; m_cur = 0; m_state = 0; m_rev = 0; m_ovf = 0; m_emp = 0;
  endtask

  task automatic m_apply(input bit c, input bit w, input int n, input bit s, input bit a, input bit rv);
    if (c) begin
      m_reset();
    end else if (m_state == 0) begin
      if (s) begin
        if (m_len > 0) begin m_state = 1; m_rev = rv; m_cur = rv ? m_len - 1 : 0; end
        else m_emp = 1;
      end else if (w) begin
        if (m_len < DP) begin m_mem[m_len] = n; m_len++; end
        else m_ovf = 1;
      end
    end else if (m_state == 1) begin
      if (a) begin
        if (m_rev ? (m_cur == 0) : (m_cur == m_len - 1)) m_state = 2;
        else m_cur = m_rev ? m_cur - 1 : m_cur + 1;
      end
    end else if (s) begin
      m_state = 1; m_rev = rv; m_cur = rv ? m_len - 1 : 0;
    end
  endtask

  function automatic int node_at(int i);
    return (i >= 0 && i < m_len) ? m_mem[i] : 31;
  endfunction
  function automatic int exp_prev();
    return (m_state == 0) ? 31 : (m_rev ? node_at(m_cur + 1) : node_at(m_cur - 1));
  endfunction
  function automatic int exp_curr();
    return (m_state == 0) ? 31 : node_at(m_cur);
  endfunction
  function automatic int exp_next();
    return (m_state == 0) ? 31 : (m_rev ? node_at(m_cur - 1) : node_at(m_cur + 1));
  endfunction

  // One input pulse for one cycle, then one quiet cycle so node outputs settle.
  task automatic pulse(input bit c, input bit w, input logic [4:0] n, input bit s, input bit a, input bit rv);
    clr = c; wr_en = w; wr_node = n; start = s; advance = a;
`ifdef PATH_SEQ_REVERSE_EN
    rev = rv;
`endif
    m_apply(c, w, int'(n), s, a, rv);
    @(posedge clk_3125k); #1;
    clr = 0; wr_en = 0; start = 0; advance = 0;
    @(posedge clk_3125k); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; wr_en = 0; wr_node = 5'd3; start = 0; advance = 0;
`ifdef PATH_SEQ_REVERSE_EN
    rev = 0;
`endif
    m_reset();
    repeat (2) @(posedge clk_3125k); #1;
    checks++;
    if ({prev_node, curr_node, next_node} !== {5'd31, 5'd31, 5'd31}) begin
      errors++; $display("FAIL reset_nodes got %0d/%0d/%0d exp 31/31/31", prev_node, curr_node, next_node);
    end
    checks++;
    if ({cursor, path_len, busy, done, err_overflow, err_empty} !== {5'd0, 6'd0, 4'b0000}) begin
      errors++; $display("FAIL reset_status got cur %0d len %0d b%0b d%0b o%0b e%0b exp zeros",
                         cursor, path_len, busy, done, err_overflow, err_empty);
    end
    rst_n = 1;
    @(posedge clk_3125k); #1;
  endtask

  task automatic test_example_path();
    int ex[14] = '{0, 1, 29, 20, 24, 25, 26, 27, 26, 28, 29, 20, 21, 22};
    pulse(1, 0, 0, 0, 0, 0);
    foreach (ex[i]) pulse(0, 1, 5'(ex[i]), 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    checks++;
    if ({path_len, busy, prev_node, curr_node, next_node} !== {6'd14, 1'b1, 5'd31, 5'd0, 5'd1}) begin
      errors++; $display("FAIL ex_start got len %0d busy %0b %0d/%0d/%0d exp 14 1 31/0/1",
                         path_len, busy, prev_node, curr_node, next_node);
    end
    repeat (3) pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({cursor, prev_node, curr_node, next_node} !== {5'd3, 5'd29, 5'd20, 5'd24}) begin
      errors++; $display("FAIL ex_adv3 got cur %0d %0d/%0d/%0d exp 3 29/20/24", cursor, prev_node, curr_node, next_node);
    end
    repeat (10) pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({cursor, busy, prev_node, curr_node, next_node} !== {5'd13, 1'b1, 5'd21, 5'd22, 5'd31}) begin
      errors++; $display("FAIL ex_last got cur %0d busy %0b %0d/%0d/%0d exp 13 1 21/22/31",
                         cursor, busy, prev_node, curr_node, next_node);
    end
    pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({done, busy, cursor, curr_node} !== {1'b1, 1'b0, 5'd13, 5'd22}) begin
      errors++; $display("FAIL ex_done got done %0b busy %0b cur %0d curr %0d exp 1 0 13 22", done, busy, cursor, curr_node);
    end
    pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({done, cursor, prev_node, curr_node, next_node} !== {1'b1, 5'd13, 5'd21, 5'd22, 5'd31}) begin
      errors++; $display("FAIL ex_hold got done %0b cur %0d %0d/%0d/%0d exp 1 13 21/22/31",
                         done, cursor, prev_node, curr_node, next_node);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] w33[33];
    pulse(1, 0, 0, 0, 0, 0);
    foreach (w33[i]) begin
      w33[i] = 5'($urandom_range(0, 30));
      pulse(0, 1, w33[i], 0, 0, 0);
    end
    checks++;
    if ({path_len, err_overflow} !== {6'd32, 1'b1}) begin
      errors++; $display("FAIL ovf_len got len %0d ovf %0b exp 32 1", path_len, err_overflow);
    end
    pulse(0, 0, 0, 1, 0, 0);
    checks++;
    if ({busy, curr_node, err_overflow} !== {1'b1, w33[0], 1'b1}) begin
      errors++; $display("FAIL ovf_start got busy %0b curr %0d ovf %0b exp 1 %0d 1", busy, curr_node, err_overflow, w33[0]);
    end
    repeat (31) pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({cursor, prev_node, curr_node, next_node} !== {5'd31, w33[30], w33[31], 5'd31}) begin
      errors++; $display("FAIL ovf_entry31 got cur %0d %0d/%0d/%0d exp 31 %0d/%0d/31",
                         cursor, prev_node, curr_node, next_node, w33[30], w33[31]);
    end
  endtask

  task automatic test_empty();
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    checks++;
    if ({busy, done, err_empty, curr_node} !== {1'b0, 1'b0, 1'b1, 5'd31}) begin
      errors++; $display("FAIL empty_start got busy %0b done %0b emp %0b curr %0d exp 0 0 1 31", busy, done, err_empty, curr_node);
    end
    pulse(1, 0, 0, 0, 0, 0);
    checks++;
    if (err_empty !== 1'b0) begin
      errors++; $display("FAIL empty_clr got emp %0b exp 0", err_empty);
    end
    pulse(0, 1, 5'd5, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    checks++;
    if ({prev_node, curr_node, next_node} !== {5'd31, 5'd5, 5'd31}) begin
      errors++; $display("FAIL single got %0d/%0d/%0d exp 31/5/31", prev_node, curr_node, next_node);
    end
    pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL single_done got done %0b busy %0b exp 1 0", done, busy);
    end
  endtask

  task automatic test_clr_priority();
    pulse(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) pulse(0, 1, 5'($urandom_range(0, 30)), 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    repeat (4) pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if (cursor !== 5'd4) begin
      errors++; $display("FAIL clr_pre got cur %0d exp 4", cursor);
    end
    clr = 1; advance = 1; wr_en = 1; start = 1; wr_node = 5'd9;
    m_apply(1, 1, 9, 1, 1, 0);
    @(posedge clk_3125k); #1;
    clr = 0; advance = 0; wr_en = 0; start = 0;
    checks++;
    if ({busy, done, path_len, cursor, prev_node, curr_node, next_node} !==
        {1'b0, 1'b0, 6'd0, 5'd0, 5'd31, 5'd31, 5'd31}) begin
      errors++; $display("FAIL clr_prio got b%0b d%0b len %0d cur %0d %0d/%0d/%0d exp 0 0 0 0 31/31/31",
                         busy, done, path_len, cursor, prev_node, curr_node, next_node);
    end
    @(posedge clk_3125k); #1;
  endtask

  task automatic test_precedence();
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 1, 5'd11, 0, 0, 0);
    pulse(0, 1, 5'd12, 0, 0, 0);
    pulse(0, 1, 5'd17, 1, 0, 0);
    checks++;
    if ({path_len, busy, curr_node, next_node} !== {6'd2, 1'b1, 5'd11, 5'd12}) begin
      errors++; $display("FAIL prec_start_wr got len %0d busy %0b curr %0d next %0d exp 2 1 11 12",
                         path_len, busy, curr_node, next_node);
    end
    pulse(0, 1, 5'd4, 1, 1, 0);
    checks++;
    if ({path_len, cursor, curr_node, busy} !== {6'd2, 5'd1, 5'd12, 1'b1}) begin
      errors++; $display("FAIL prec_run got len %0d cur %0d curr %0d busy %0b exp 2 1 12 1",
                         path_len, cursor, curr_node, busy);
    end
  endtask

  task automatic test_reset_midrun();
    pulse(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse(0, 1, 5'(i + 2), 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    rst_n = 0;
    @(posedge clk_3125k); #1;
    rst_n = 1;
    m_reset();
    checks++;
    if ({busy, path_len, cursor, curr_node} !== {1'b0, 6'd0, 5'd0, 5'd31}) begin
      errors++; $display("FAIL midrun_rst got busy %0b len %0d cur %0d curr %0d exp 0 0 0 31", busy, path_len, cursor, curr_node);
    end
    @(posedge clk_3125k); #1;
  endtask

`ifdef PATH_SEQ_REVERSE_EN
  task automatic test_reverse();
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 1, 5'd3, 0, 0, 0);
    pulse(0, 1, 5'd7, 0, 0, 0);
    pulse(0, 1, 5'd9, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 1);
    checks++;
    if ({prev_node, curr_node, next_node, cursor} !== {5'd31, 5'd9, 5'd7, 5'd2}) begin
      errors++; $display("FAIL rev_start got %0d/%0d/%0d cur %0d exp 31/9/7 2", prev_node, curr_node, next_node, cursor);
    end
    repeat (2) pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({prev_node, curr_node, next_node, busy} !== {5'd7, 5'd3, 5'd31, 1'b1}) begin
      errors++; $display("FAIL rev_end got %0d/%0d/%0d busy %0b exp 7/3/31 1", prev_node, curr_node, next_node, busy);
    end
    pulse(0, 0, 0, 0, 1, 0);
    checks++;
    if ({done, busy, cursor} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL rev_done got done %0b busy %0b cur %0d exp 1 0 0", done, busy, cursor);
    end
  endtask
`endif

  task automatic test_random();
    bit c, w, s, a, rv;
    pulse(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      c  = ($urandom_range(0, 99) < 3);
      w  = ($urandom_range(0, 99) < 55);
      s  = ($urandom_range(0, 99) < 12);
      a  = ($urandom_range(0, 99) < 45);
      rv = 1'b0;
`ifdef PATH_SEQ_REVERSE_EN
      rv = 1'($urandom_range(0, 1));
`endif
      pulse(c, w, 5'($urandom_range(0, 31)), s, a, rv);
      checks++;
      if ({prev_node, curr_node, next_node} !== {5'(exp_prev()), 5'(exp_curr()), 5'(exp_next())}) begin
        errors++; $display("FAIL rand_nodes op %0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                           k, prev_node, curr_node, next_node, exp_prev(), exp_curr(), exp_next());
      end
      checks++;
      if ({cursor, path_len, busy, done, err_overflow, err_empty} !==
          {5'(m_cur), 6'(m_len), (m_state == 1), (m_state == 2), m_ovf, m_emp}) begin
        errors++; $display("FAIL rand_status op %0d got cur %0d len %0d b%0b d%0b o%0b e%0b exp cur %0d len %0d mode %0d o%0b e%0b",
                           k, cursor, path_len, busy, done, err_overflow, err_empty, m_cur, m_len, m_state, m_ovf, m_emp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_example_path();
    test_overflow();
    test_empty();
    test_clr_priority();
    test_precedence();
    test_reset_midrun();
`ifdef PATH_SEQ_REVERSE_EN
    test_reverse();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
- Parametrised, loadable successor to the fixed node-path lookup used by the bot navigation logic.
- Path nodes are written into an internal register file at run time.
- A cursor steps through the path on each node-reached pulse, presenting registered previous, current and next node IDs to the turn/motor decision logic.
- Provides run/done status and flags empty-path and overflow errors.

Parameters:
NODE_W, 5, width of a node ID
DEPTH, 32, maximum number of path entries
PTR_W, $clog2(DEPTH), cursor and length width (derived, not overridden)

Ports:
clk_3125k  in  1  system clock (3.125 MHz)
rst_n  in  1  synchronous active-low reset
clr  in  1  pulse: empty the path, return to IDLE
wr_en  in  1  append wr_node to the path (IDLE only)
wr_node  in  NODE_W  node ID to append
start  in  1  pulse: begin traversal at index 0
advance  in  1  pulse: current node reached, step the cursor
prev_node  out  NODE_W  node at cursor-1, or INVALID_NODE
curr_node  out  NODE_W  node at cursor, or INVALID_NODE
next_node  out  NODE_W  node at cursor+1, or INVALID_NODE
cursor  out  PTR_W  current index
path_len  out  PTR_W+1  number of stored nodes
busy  out  1  high in RUN
done  out  1  high in DONE
err_overflow  out  1  sticky: write attempted while full
err_empty  out  1  sticky: start issued with path_len==0

Behaviour:
- Reset (rst_n low at a clk_3125k edge):
  - state=IDLE; path_len=0; cursor=0; busy=0; done=0.
  - Both error flags clear.
  - prev/curr/next_node = INVALID_NODE (all ones). Memory contents are don't-care.
- All outputs are registered. Node outputs reflect a new cursor one cycle after the causing edge.
- IDLE:
  - wr_en with path_len<DEPTH stores wr_node at index path_len; path_len increments next cycle.
  - wr_en with path_len==DEPTH drops the write and sets err_overflow.
  - start with path_len>0 → RUN, cursor=0.
  - start with path_len==0 → stay IDLE, set err_empty.
  - advance is ignored.
- RUN:
  - advance with cursor<path_len-1 → cursor+1.
  - advance with cursor==path_len-1 → DONE; cursor holds.
  - wr_en and start are ignored.
- DONE:
  - Outputs hold; advance is ignored.
  - start restarts RUN at cursor 0 with the same path.
  - wr_en is ignored.
- clr in any state:
  - → IDLE; path_len=0; cursor=0; node outputs=INVALID_NODE.
  - Error flags clear.
  - clr has priority over every other input in the same cycle.
- Precedence within a cycle: rst_n > clr > start > advance > wr_en.
- Node output rules:
  - prev_node = INVALID_NODE when cursor==0; no wrap to the last entry.
  - next_node = INVALID_NODE when cursor==path_len-1.
  - curr_node = INVALID_NODE outside RUN/DONE.
- Repeated node IDs in a path are legal and each entry is distinct, e.g. 26,27,26.
- Cursor arithmetic is unsigned PTR_W. path_len is PTR_W+1 so that DEPTH is representable.

Optional Feature:
- Macro: PATH_SEQ_REVERSE_EN.
- When defined:
  - Extra input rev (1 bit) is sampled on start.
  - With rev=1, traversal begins at cursor=path_len-1 and advance decrements the cursor; DONE is reached at cursor 0.
  - prev_node/next_node swap roles: next = cursor-1, prev = cursor+1. INVALID_NODE is returned at the ends.
  - Used for the return trip over a stored path.
- When undefined: there is no rev port and traversal is forward only.

Decomposition:
- Package path_pkg holds:
  - NODE_W default and node_t typedef.
  - INVALID_NODE = {NODE_W{1'b1}}.
  - seq_state_t enum: IDLE, RUN, DONE.
- One sub-module, path_mem:
  - DEPTH×NODE_W register file.
  - One synchronous write port.
  - Three combinational read ports, each with an out-of-range → INVALID_NODE guard.
- The FSM, cursor, error flags and output registers live in path_sequencer.

Test Plan:
- Load 0,1,29,20,24,25,26,27,26,28,29,20,21,22, then start: path_len=14. Cycle after start gives prev=31, curr=0, next=1. Three advances give prev=29, curr=20, next=24.
- Advance to index 13: curr=22, next=31, busy=1. One more advance gives done=1, busy=0; a further advance leaves the outputs unchanged.
- Write 33 nodes with DEPTH=32: path_len=32, err_overflow=1, entry 31 holds the 32nd write. start is still accepted.
- start with an empty path: state stays IDLE and err_empty=1. Then clr clears err_empty; a write of node 5 followed by start gives curr=5, prev=31, next=31, and done after one advance.
- In RUN at cursor 4, assert clr together with advance: the next cycle shows IDLE, path_len=0, all node outputs=31.
- With PATH_SEQ_REVERSE_EN, path 3,7,9 and start with rev=1: curr=9, next=7, prev=31. Two advances give curr=3, next=31; one more gives done.
